bcd_counter_mux7seg: RTL and testbench
======================================

Name: bcd_counter_mux7seg

Overview:
Parametrised N-digit BCD up/down counter with a time-multiplexed 7-segment display driver. It generalises the fixed 3-digit display counter: configurable digit count, tick and scan prescalers, up/down direction, synchronous load, wrap pulse, leading-zero blanking and output polarity. It sits directly under the TinyTapeout top wrapper, which maps seg_out to uo_out and digit_sel to uio_out.

Parameters:
DIGITS, 3, number of BCD digits (1..8)
TICK_DIV, 1000000, clocks per count tick while enabled (>=1)
SCAN_DIV, 1000, clocks per display digit slot (>=1)
SEG_ACTIVE_LOW, 0, 1 = segments lit when 0
DIG_ACTIVE_LOW, 0, 1 = digit_sel asserted when 0
BLANK_LZ, 1, 1 = blank leading zero digits

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset; synchronous, active-low
enable  in  1  count enable; gates the tick prescaler only
up_dn  in  1  1 = count up, 0 = count down
load  in  1  synchronous load strobe
load_val  in  4*DIGITS  BCD value for load, digit 0 = bits [3:0]
seg_out  out  7  {g,f,e,d,c,b,a} for the selected digit
digit_sel  out  DIGITS  one-hot digit enable, bit i = digit i
count_bcd  out  4*DIGITS  current count, registered
wrap  out  1  one-cycle pulse on wrap-around

Behaviour:
- Reset (rst_n=0 at a clk edge): count_bcd=0, tick prescaler=0, scan counter=0, scan index=0, wrap=0, seg_out all unlit, digit_sel all deasserted (both per polarity params). Reset mid-operation overrides load and tick in the same cycle.
- Tick prescaler: increments only while enable=1. Reaching TICK_DIV-1 wraps it to 0 and produces an internal tick that cycle. enable=0 holds the prescaler value; it does not clear it. TICK_DIV=1 gives a tick every enabled cycle.
- Count update on tick, BCD ripple. Up: digit 9 goes to 0 and carries into the next digit. Down: digit 0 goes to 9 and borrows. Full wrap: up from all-9s goes to 0; down from 0 goes to all-9s. Either wrap drives wrap=1 for exactly the next cycle; otherwise wrap=0.
- load=1: count_bcd <= load_val next cycle, tick prescaler cleared, wrap=0. load has priority over a simultaneous tick; the tick is discarded. Any nibble >9 in load_val loads as 0. load works regardless of enable.
- up_dn is sampled on the tick cycle only. Changing it between ticks has no side effects.
- Scan: free-running, independent of enable and load. A scan counter counts 0..SCAN_DIV-1. On its wrap, the scan index advances 0,1,..,DIGITS-1,0.
- Display registers update every cycle. digit_sel = onehot(scan index). seg_out = decode(count nibble at scan index). Latency is 1 cycle from count/index change to outputs. digit_sel and seg_out always change on the same edge, so there is no ghosting cycle.
- Decode (active-high, g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Nibbles >9 are unreachable; decode them as unlit.
- Leading-zero blanking (BLANK_LZ=1): digit i>0 is unlit if it and all higher digits are 0. Digit 0 is never blanked. digit_sel still asserts during blanked slots.
- Polarity: SEG_ACTIVE_LOW inverts seg_out. DIG_ACTIVE_LOW inverts digit_sel. The parameters are independent.
- count_bcd is the internal register, visible the cycle after update.

Test Plan:
1. DIGITS=3, TICK_DIV=2, enable=1, up_dn=1, from reset -> count_bcd increments every 2 cycles: 000,001,..,009,010; at 099->100 the carry ripples correctly.
2. load_val=999, then up tick -> count_bcd=000, single-cycle wrap=1. Then load 000, up_dn=0, one tick -> 999, wrap=1 for one cycle.
3. Assert load=1 (load_val=0x5A7) on the same cycle a tick fires -> count_bcd=0x507 (invalid nibble A loads as 0), tick discarded, prescaler restarts at 0.
4. SCAN_DIV=4, count=0x042, BLANK_LZ=1 -> digit_sel cycles 001,010,100 every 4 cycles. seg_out is 5B, 66, 00 in those slots, aligned with digit_sel on the same edge.
5. SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, count=8 -> digit 0 slot shows seg_out=00, digit_sel=110. Blanked digits show seg_out=7F.
6. Pull rst_n low for one cycle mid-count, with enable=1 and load=1 also asserted -> next cycle count=0, wrap=0, outputs unlit/deasserted. Counting resumes from 0 after TICK_DIV enabled cycles.

Source files
------------

// File: rtl/bcd_counter_mux7seg.sv
// N-digit BCD up/down counter with a time-multiplexed 7-segment display driver.
// Tick and scan prescalers run from clk; outputs are registered, one cycle behind count/index.
module bcd_counter_mux7seg #(
  parameter int   DIGITS         = 3,
  parameter int   TICK_DIV       = 1000000,
  parameter int   SCAN_DIV       = 1000,
  parameter logic SEG_ACTIVE_LOW = 1'b0,
  parameter logic DIG_ACTIVE_LOW = 1'b0,
  parameter logic BLANK_LZ       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [TW-1:0]         tick_cnt;
  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         scan_idx;
  logic                  tick;
  logic                  full_wrap;
  logic [4*DIGITS-1:0]   next_cnt;
  logic [4*DIGITS-1:0]   load_clean;
  logic [DIGITS-1:0]     lz;
  logic [3:0]            cur_nib;
  logic                  blank;
  logic [6:0]            seg_lit;
  logic [DIGITS-1:0]     onehot;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0: seg_decode = 7'h3F;
      4'd1: seg_decode = 7'h06;
      4'd2: seg_decode = 7'h5B;
      4'd3: seg_decode = 7'h4F;
      4'd4: seg_decode = 7'h66;
      4'd5: seg_decode = 7'h6D;
      4'd6: seg_decode = 7'h7D;
      4'd7: seg_decode = 7'h07;
      4'd8: seg_decode = 7'h7F;
      4'd9: seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  assign tick = enable && (tick_cnt == TW'(TICK_DIV - 1));

  // Ripple carry/borrow; carry surviving past the top digit means a full wrap.
  always_comb begin
    logic carry;
    next_cnt = count_bcd;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (up_dn) begin
          if (count_bcd[4*i +: 4] == 4'd9) next_cnt[4*i +: 4] = 4'd0;
          else begin
            next_cnt[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (count_bcd[4*i +: 4] == 4'd0) next_cnt[4*i +: 4] = 4'd9;
          else begin
            next_cnt[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    full_wrap = carry;
  end

  always_comb begin
    load_clean = '0;
    for (int i = 0; i < DIGITS; i++)
      load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
  end

  // lz[i]: digit i and every digit above it are zero.
  always_comb begin
    logic zero_above;
    lz         = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (count_bcd[4*i +: 4] == 4'd0);
      lz[i]      = zero_above;
    end
  end

  always_comb begin
    cur_nib = count_bcd[4*scan_idx +: 4];
    blank   = BLANK_LZ && (scan_idx != '0) && lz[scan_idx];
    seg_lit = blank ? 7'h00 : seg_decode(cur_nib);
    onehot  = DIGITS'(1) << scan_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_bcd <= '0;
      tick_cnt  <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count_bcd <= load_clean;
        tick_cnt  <= '0;
      end else if (tick) begin
        count_bcd <= next_cnt;
        tick_cnt  <= '0;
        wrap      <= full_wrap;
      end else if (enable) begin
        tick_cnt  <= tick_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      scan_idx  <= '0;
      seg_out   <= SEG_OFF;
      digit_sel <= DIG_OFF;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg_out   <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
      digit_sel <= DIG_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

endmodule

// File: tb/tb_bcd_counter_mux7seg.sv
// Bench for bcd_counter_mux7seg: two instances (active-high and active-low outputs)
// checked against an integer-valued reference model, load vectors and corner sequences.
module tb_bcd_counter_mux7seg;

  localparam int D  = 3;
  localparam int TD = 2;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n, enable, up_dn, load;
  logic [11:0]   load_val;
  logic [6:0]    seg_a, seg_b;
  logic [2:0]    sel_a, sel_b;
  logic [11:0]   cnt_a, cnt_b;
  logic          wrap_a, wrap_b;

  always #5 clk = ~clk;

  bcd_counter_mux7seg #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD),
                        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .load(load), .load_val(load_val),
    .seg_out(seg_a), .digit_sel(sel_a), .count_bcd(cnt_a), .wrap(wrap_a));

  bcd_counter_mux7seg #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD),
                        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .load(load), .load_val(load_val),
    .seg_out(seg_b), .digit_sel(sel_b), .count_bcd(cnt_b), .wrap(wrap_b));

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: the count as a plain integer 0..999.
  int          m_cnt, m_presc, m_scnt, m_sidx;
  logic        m_wrap;
  logic [6:0]  m_seg;
  logic [2:0]  m_sel;
  logic [6:0]  seg_tab [10];

  typedef struct {
    logic [11:0] lv;
    logic [11:0] exp;
  } load_vec_t;
  load_vec_t lt [6];

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int clean_val(input logic [11:0] lv);
    int v = 0;
    for (int i = 0; i < D; i++)
      if (lv[4*i +: 4] <= 4'd9) v = v + int'(lv[4*i +: 4]) * pow10(i);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int         dig;
    bit         blank;
    logic [6:0] seg_inv;
    logic [2:0] sel_inv;
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_presc = 0; m_scnt = 0; m_sidx = 0; m_wrap = 1'b0;
      m_seg = 7'h00; m_sel = 3'b000;
    end else begin
      dig   = (m_cnt / pow10(m_sidx)) % 10;
      blank = (m_sidx > 0) && (m_cnt < pow10(m_sidx));
      m_seg = blank ? 7'h00 : seg_tab[dig];
      m_sel = 3'(1 << m_sidx);
      if (m_scnt == SD - 1) begin
        m_scnt = 0;
        m_sidx = (m_sidx + 1) % D;
      end else m_scnt++;
      m_wrap = 1'b0;
      if (load) begin
        m_cnt   = clean_val(load_val);
        m_presc = 0;
      end else if (enable) begin
        if (m_presc == TD - 1) begin
          m_presc = 0;
          if (up_dn) begin
            m_wrap = (m_cnt == pow10(D) - 1);
            m_cnt  = (m_cnt + 1) % pow10(D);
          end else begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt == 0) ? pow10(D) - 1 : m_cnt - 1;
          end
        end else m_presc++;
      end
    end
    #1;
    seg_inv = ~m_seg;
    sel_inv = ~m_sel;
    check("count_a", 32'(cnt_a), 32'(to_bcd(m_cnt)));
    check("wrap_a",  32'(wrap_a), 32'(m_wrap));
    check("seg_a",   32'(seg_a), 32'(m_seg));
    check("sel_a",   32'(sel_a), 32'(m_sel));
    check("count_b", 32'(cnt_b), 32'(to_bcd(m_cnt)));
    check("wrap_b",  32'(wrap_b), 32'(m_wrap));
    check("seg_b",   32'(seg_b), 32'(seg_inv));
    check("sel_b",   32'(sel_b), 32'(sel_inv));
  endtask

  task automatic do_load(input logic [11:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    lt[0] = '{12'h5A7, 12'h507};
    lt[1] = '{12'hFFF, 12'h000};
    lt[2] = '{12'h999, 12'h999};
    lt[3] = '{12'h0B9, 12'h009};
    lt[4] = '{12'hA42, 12'h042};
    lt[5] = '{12'h123, 12'h123};

    m_cnt = 0; m_presc = 0; m_scnt = 0; m_sidx = 0; m_wrap = 1'b0; m_seg = '0; m_sel = '0;
    rst_n = 1'b0; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    step(); step();
    check("reset_count", 32'(cnt_a), 32'h000);
    check("reset_sel_b", 32'(sel_b), 32'h7);
    check("reset_seg_b", 32'(seg_b), 32'h7F);
    rst_n = 1'b1;

    // Count up from reset; two cycles per tick.
    enable = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("up_010", 32'(cnt_a), 32'h010);
    do_load(12'h098);
    for (int i = 0; i < 4; i++) step();
    check("carry_100", 32'(cnt_a), 32'h100);

    // Up wrap from 999, then down wrap from 000.
    do_load(12'h999);
    step(); step();
    check("upwrap_cnt", 32'(cnt_a), 32'h000);
    check("upwrap_pulse", 32'(wrap_a), 32'h1);
    step();
    check("upwrap_clear", 32'(wrap_a), 32'h0);
    up_dn = 1'b0;
    do_load(12'h000);
    step(); step();
    check("dnwrap_cnt", 32'(cnt_a), 32'h999);
    check("dnwrap_pulse", 32'(wrap_a), 32'h1);
    step();
    check("dnwrap_clear", 32'(wrap_a), 32'h0);

    // Load on the same cycle a tick fires: tick discarded, prescaler restarts.
    up_dn = 1'b1;
    do_load(12'h100);
    step();
    do_load(12'h5A7);
    check("ld_tick_cnt", 32'(cnt_a), 32'h507);
    check("ld_tick_wrap", 32'(wrap_a), 32'h0);
    step();
    check("ld_presc_hold", 32'(cnt_a), 32'h507);
    step();
    check("ld_presc_tick", 32'(cnt_a), 32'h508);

    // Load vector table, with enable off so the count holds.
    enable = 1'b0;
    foreach (lt[k]) begin
      do_load(lt[k].lv);
      check("ldvec_a", 32'(cnt_a), 32'(lt[k].exp));
      check("ldvec_b", 32'(cnt_b), 32'(lt[k].exp));
      check("ldvec_wrap", 32'(wrap_a), 32'h0);
    end

    // Scan slots with leading-zero blanking on 042.
    do_load(12'h042);
    for (int i = 0; i < 16; i++) begin
      step();
      case (sel_a)
        3'b001:  check("scan_d0", 32'(seg_a), 32'h5B);
        3'b010:  check("scan_d1", 32'(seg_a), 32'h66);
        3'b100:  check("scan_d2", 32'(seg_a), 32'h00);
        default: check("scan_onehot", 32'(sel_a), 32'h1);
      endcase
    end

    // Active-low instance showing 008.
    do_load(12'h008);
    step();
    for (int i = 0; i < 12; i++) begin
      step();
      if (sel_b == 3'b110) check("al_d0", 32'(seg_b), 32'h00);
      else                 check("al_blank", 32'(seg_b), 32'h7F);
    end

    // Reset overrides load and tick.
    enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0; load = 1'b1; load_val = 12'h333;
    step();
    check("rst_cnt", 32'(cnt_a), 32'h000);
    check("rst_wrap", 32'(wrap_a), 32'h0);
    check("rst_seg_a", 32'(seg_a), 32'h00);
    check("rst_sel_a", 32'(sel_a), 32'h0);
    check("rst_seg_b", 32'(seg_b), 32'h7F);
    rst_n = 1'b1; load = 1'b0;
    step();
    check("rst_resume0", 32'(cnt_a), 32'h000);
    step();
    check("rst_resume1", 32'(cnt_a), 32'h001);

    // Randomised run against the model.
    for (int i = 0; i < 2500; i++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      enable = ($urandom_range(0, 3) != 0);
      up_dn  = ($urandom_range(0, 99) < 50);
      load   = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       load_val = 12'h999;
        1:       load_val = 12'h000;
        default: load_val = 12'($urandom);
      endcase
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
